// File: rtl/main_fsm.sv
// Multicycle-processor main control FSM: Moore outputs decoded from a 4-bit state register.
// Optional retired-instruction counter on InstrCount when MAIN_FSM_INSTR_CNT_EN is defined.
module main_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic        NextPC,
    output logic        RegW,
    output logic        MemW,
    output logic        Branch,
    output logic        ALUOp
`ifdef MAIN_FSM_INSTR_CNT_EN
    ,
    output logic [31:0] InstrCount
`endif
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // Only the immediate and load/store bits steer this FSM; the rest belong to the ALU decoder.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMRD:    AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER: ALUOp = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB:    RegW = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: ;
        endcase
        // While reset is held, present a quiet fetch: selects as in FETCH, no strobes.
        if (reset) begin
            IRWrite   = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            NextPC    = 1'b0;
            RegW      = 1'b0;
            MemW      = 1'b0;
            Branch    = 1'b0;
            ALUOp     = 1'b0;
        end
    end

`ifdef MAIN_FSM_INSTR_CNT_EN
    logic [31:0] instr_cnt_q;
    logic [31:0] instr_cnt_d;
    logic        retire;

    // Every instruction except an undefined one retires from one of these four states.
    assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWR) ||
                    (state_q == S_ALUWB) || (state_q == S_BRANCH);

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        if (retire) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_cnt_q <= 32'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign InstrCount = instr_cnt_q;
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: latency/decode vector table, reset corner case,
// and random instruction streams checked against a per-instruction phase model.
module tb_main_fsm;

    logic        clk;
    logic        reset;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic        IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
`ifdef MAIN_FSM_INSTR_CNT_EN
    logic [31:0] InstrCount;
`endif

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp)
`ifdef MAIN_FSM_INSTR_CNT_EN
        ,
        .InstrCount(InstrCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word: {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
    typedef logic [12:0] ow_t;
    localparam ow_t W_F   = 13'b1_0_01_10_10_1_0_0_0_0;
    localparam ow_t W_D   = 13'b0_0_01_10_10_0_0_0_0_0;
    localparam ow_t W_MA  = 13'b0_0_00_01_00_0_0_0_0_0;
    localparam ow_t W_MR  = 13'b0_1_00_00_00_0_0_0_0_0;
    localparam ow_t W_MWB = 13'b0_0_00_00_01_0_1_0_0_0;
    localparam ow_t W_MW  = 13'b0_1_00_00_00_0_0_1_0_0;
    localparam ow_t W_ER  = 13'b0_0_00_00_00_0_0_0_0_1;
    localparam ow_t W_EI  = 13'b0_0_00_01_00_0_0_0_0_1;
    localparam ow_t W_AW  = 13'b0_0_00_00_00_0_1_0_0_0;
    localparam ow_t W_BR  = 13'b0_0_00_01_10_0_0_0_1_0;
    localparam ow_t W_RST = 13'b0_0_01_10_10_0_0_0_0_0;

    ow_t dut_w;
    assign dut_w = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycles from FETCH entry to the next FETCH entry for one instruction.
    function automatic int model_len(input logic [1:0] op, input logic [5:0] funct);
        case (op)
            2'b00:   return 4;
            2'b01:   return funct[0] ? 5 : 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    // Expected output word in cycle k of an instruction's execution.
    function automatic ow_t model_word(input logic [1:0] op, input logic [5:0] funct, input int k);
        ow_t mem_ld [5];
        ow_t mem_st [4];
        if (k == 0) return W_F;
        if (k == 1) return W_D;
        mem_ld = '{W_F, W_D, W_MA, W_MR, W_MWB};
        mem_st = '{W_F, W_D, W_MA, W_MW};
        case (op)
            2'b00:   return (k == 2) ? (funct[5] ? W_EI : W_ER) : W_AW;
            2'b01:   return funct[0] ? mem_ld[k] : mem_st[k];
            2'b10:   return W_BR;
            default: return W_F;
        endcase
    endfunction

    // Enters at a negedge inside FETCH; returns at the negedge inside the following FETCH.
    task automatic run_inst(input logic [1:0] op, input logic [5:0] funct, input string tag);
        int len;
        len = model_len(op, funct);
        for (int k = 0; k < len; k++) begin
            #1;
            check($sformatf("%s_k%0d", tag, k), {19'd0, dut_w}, {19'd0, model_word(op, funct, k)});
`ifdef MAIN_FSM_INSTR_CNT_EN
            if (k == 0) check($sformatf("%s_cnt", tag), InstrCount, exp_cnt);
`endif
            if (k == 1 || (op == 2'b01 && k == 2)) begin
                Op = op;
                Funct = funct;
            end else begin
                Op = 2'($urandom_range(0, 3));
                Funct = 6'($urandom);
            end
            @(negedge clk);
        end
        if (op != 2'b11) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_outs", {19'd0, dut_w}, {19'd0, W_RST});
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 32'd0;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        int         lat;
        ow_t        w2;
        ow_t        w3;
    } vec_t;

    vec_t tbl [6];
    logic [1:0] r_op;
    logic [5:0] r_funct;

    initial begin
        tbl[0] = '{2'b01, 6'b000001, 5, W_MA, W_MR};
        tbl[1] = '{2'b01, 6'b000000, 4, W_MA, W_MW};
        tbl[2] = '{2'b00, 6'b100100, 4, W_EI, W_AW};
        tbl[3] = '{2'b00, 6'b000100, 4, W_ER, W_AW};
        tbl[4] = '{2'b10, 6'b000000, 3, W_BR, W_F};
        tbl[5] = '{2'b11, 6'b000000, 2, W_F,  W_F};

        reset = 1'b1;
        Op = 2'b00;
        Funct = 6'd0;
        @(negedge clk);
        do_reset();
        #1;
        check("post_reset_fetch", {19'd0, dut_w}, {19'd0, W_F});

        // Latency and decode table: inputs held constant for the whole instruction.
        for (int i = 0; i < 6; i++) begin
            $display("vec %0d: op=%b funct=%b latency=%0d", i, tbl[i].op, tbl[i].funct, tbl[i].lat);
            for (int c = 0; c < tbl[i].lat; c++) begin
                #1;
                check($sformatf("tbl%0d_irw_c%0d", i, c), {31'd0, IRWrite}, (c == 0) ? 32'd1 : 32'd0);
                if (c == 1) check($sformatf("tbl%0d_decode", i), {19'd0, dut_w}, {19'd0, W_D});
                if (c == 2) check($sformatf("tbl%0d_w2", i), {19'd0, dut_w}, {19'd0, tbl[i].w2});
                if (c == 3) check($sformatf("tbl%0d_w3", i), {19'd0, dut_w}, {19'd0, tbl[i].w3});
                Op = tbl[i].op;
                Funct = tbl[i].funct;
                @(negedge clk);
            end
        end
        #1;
        check("tbl_final_fetch", {31'd0, IRWrite}, 32'd1);

        // Reset asserted while in MEMRD.
        $display("seq: reset during MEMRD");
        do_reset();
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("mrst_k%0d", k), {19'd0, dut_w}, {19'd0, model_word(2'b01, 6'b000001, k)});
            Op = 2'b01;
            Funct = 6'b000001;
            @(negedge clk);
        end
        #1;
        check("mrst_memrd", {19'd0, dut_w}, {19'd0, W_MR});
        reset = 1'b1;
        #1;
        check("mrst_gated", {19'd0, dut_w}, {19'd0, W_RST});
        @(negedge clk);
        #1;
        check("mrst_held", {19'd0, dut_w}, {19'd0, W_RST});
        reset = 1'b0;
        exp_cnt = 32'd0;
        #1;
        check("mrst_release_fetch", {19'd0, dut_w}, {19'd0, W_F});
        @(negedge clk);
        #1;
        check("mrst_decode", {19'd0, dut_w}, {19'd0, W_D});
        Op = 2'b11;
        @(negedge clk);

        // Random instruction stream; junk on Op/Funct outside the sampling states.
        for (int n = 0; n < 150; n++) begin
            r_op = 2'($urandom_range(0, 3));
            r_funct = 6'($urandom);
            $display("rnd %0d: op=%b funct=%b", n, r_op, r_funct);
            run_inst(r_op, r_funct, $sformatf("rnd%0d", n));
        end

`ifdef MAIN_FSM_INSTR_CNT_EN
        $display("seq: instruction counter");
        do_reset();
        for (int n = 0; n < 3; n++) run_inst(2'b00, 6'($urandom), "cnt_dp");
        #1;
        check("cnt_three", InstrCount, 32'd3);
        dut.instr_cnt_q = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        run_inst(2'b10, 6'd0, "cnt_wrap_br");
        #1;
        check("cnt_wrap", InstrCount, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
